fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the ARM pipeline: holds the program counter, issues word fetches to a variable-latency instruction memory over a req/ready handshake, and presents {PC+4, instruction} to the IF/ID pipeline register. It sits directly upstream of IF/ID. It honours the hazard unit's freeze without dropping a returned instruction, and redirects on a taken branch from EXE, discarding any in-flight fetch.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall; same signal drives IF/ID freeze.
- branch_taken  in  1  redirect request from EXE; same signal drives IF/ID flush.
- branch_addr  in  32  redirect target, word aligned.
- imem_req  out  1  fetch request, valid address on imem_addr.
- imem_addr  out  32  fetch byte address (= pc).
- imem_ready  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- pc_out  out  32  registered PC+4 of the presented instruction.
- instr_out  out  32  registered instruction; 0 (NOP) when invalid.
- instr_valid  out  1  registered; presented pair is a real instruction.

## Operation
- Internal state:
  - pc (32b).
  - Skid buffer: skid_pc, skid_instr, skid_full.
  - 2-bit FSM: FETCH, HOLD, DRAIN.
- Output registers load when (~freeze | ~instr_valid) or on branch; otherwise they hold.
- FETCH: imem_req=1, imem_addr=pc.
  - branch_taken: pc<=branch_addr, outputs<=0/invalid, skid cleared.
    - imem_ready=1 in the same cycle: response discarded, stay FETCH.
    - imem_ready=0: go DRAIN.
  - imem_ready & output load allowed: pc_out<=pc+4, instr_out<=imem_rdata, instr_valid<=1, pc<=pc+4.
  - imem_ready & output held (freeze & instr_valid): skid<={pc+4, imem_rdata}, skid_full<=1, pc<=pc+4, go HOLD.
  - ~imem_ready & output load allowed: instr_out<=0, pc_out<=0, instr_valid<=0 (bubble).
- HOLD: imem_req=0.
  - branch_taken: redirect as above; skid cleared; go FETCH.
  - ~freeze: outputs<=skid contents, valid<=1, skid_full<=0, go FETCH.
  - Otherwise hold.
- DRAIN: imem_req=1, imem_addr holds the old address (the request is not retracted); pc already holds the target.
  - Outputs stay 0/invalid.
  - imem_ready: response discarded, go FETCH, which issues the fetch at pc.
  - A further branch_taken in DRAIN updates pc only; stay in DRAIN until ready.
- Priority: rst > branch_taken > freeze > normal.
- Arithmetic: pc+4 is modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- An old-address register (req_addr) keeps imem_addr stable while a request is outstanding.

## Timing
- Reset values: pc=0, req_addr=0, FSM=FETCH, skid_full=0, imem_req=0 while rst=1, pc_out=0, instr_out=0, instr_valid=0.
- First request: imem_req=1 with addr 0 in the first cycle after rst deasserts.
- Latency: response in cycle N (imem_ready=1) gives the outputs in cycle N+1. Zero-wait memory sustains one instruction per cycle.
- Handshake: imem_req/imem_addr stay stable from assertion until the cycle imem_ready=1. imem_ready is ignored when imem_req=0.
- Branch: outputs become invalid the cycle after branch_taken. The first target fetch has imem_req=1 that same cycle, or once DRAIN ends.
- Freeze: the output pair is held stable for every cycle freeze=1 with instr_valid=1. No instruction is lost or duplicated.
- Reset mid-request: everything returns to reset values immediately; the outstanding response is ignored.

## Test plan
- Reset then zero-wait memory returning (addr>>2)+0x100: instr_valid=1 from cycle 2; pc_out=4,8,12 with instr 0x100,0x101,0x102.
- Memory with 2-cycle latency: one valid instruction every 3 cycles with bubbles (instr_out=0) between; imem_addr stable while waiting.
- freeze=1 for 3 cycles while the response arrives: outputs hold {4,0x100}; the skid captures {8,0x101}; on release outputs become {8,0x101}, then {12,0x102}; no gap, no duplicate.
- branch_taken, branch_addr=0x40, while a fetch at 0x10 is outstanding (ready 2 cycles later): FSM=DRAIN; the 0x10 data is discarded; the next request is at 0x40; first valid pc_out=0x44.
- branch_taken in HOLD with freeze=1: skid cleared, outputs invalid; next fetch at the target.
- pc=0xFFFFFFFC fetch: next imem_addr=0; rst pulsed mid-request drops imem_req and clears all outputs asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory over req/ready, and feeds {PC+4, instruction} into IF/ID with a one-entry skid.
module fetch_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic        instr_valid
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] req_addr, req_addr_next;
   logic [31:0] skid_pc, skid_pc_next;
   logic [31:0] skid_instr, skid_instr_next;
   logic        skid_full, skid_full_next;
   logic [31:0] pc_out_next, instr_out_next;
   logic        instr_valid_next;
   logic        req_int;
   logic        load_ok;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;
   assign load_ok  = ~freeze | ~instr_valid;
   // Request is forced low while reset is held, independent of the FSM.
   assign imem_req = req_int & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= '0;
         req_addr    <= '0;
         skid_pc     <= '0;
         skid_instr  <= '0;
         skid_full   <= 1'b0;
         pc_out      <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         req_addr    <= req_addr_next;
         skid_pc     <= skid_pc_next;
         skid_instr  <= skid_instr_next;
         skid_full   <= skid_full_next;
         pc_out      <= pc_out_next;
         instr_out   <= instr_out_next;
         instr_valid <= instr_valid_next;
      end
   end

   always_comb begin
      state_next       = state;
      pc_next          = pc;
      req_addr_next    = req_addr;
      skid_pc_next     = skid_pc;
      skid_instr_next  = skid_instr;
      skid_full_next   = skid_full;
      pc_out_next      = pc_out;
      instr_out_next   = instr_out;
      instr_valid_next = instr_valid;
      req_int          = 1'b0;
      imem_addr        = pc;

      case (state)
         FETCH: begin
            req_int       = 1'b1;
            imem_addr     = pc;
            req_addr_next = pc;
            if (branch_taken) begin
               pc_next          = branch_addr;
               pc_out_next      = '0;
               instr_out_next   = '0;
               instr_valid_next = 1'b0;
               skid_full_next   = 1'b0;
               skid_pc_next     = '0;
               skid_instr_next  = '0;
               // An unanswered request must still be drained before retargeting.
               state_next       = imem_ready ? FETCH : DRAIN;
            end else if (imem_ready) begin
               pc_next = pc_plus4;
               if (load_ok) begin
                  pc_out_next      = pc_plus4;
                  instr_out_next   = imem_rdata;
                  instr_valid_next = 1'b1;
               end else begin
                  skid_pc_next    = pc_plus4;
                  skid_instr_next = imem_rdata;
                  skid_full_next  = 1'b1;
                  state_next      = HOLD;
               end
            end else if (load_ok) begin
               pc_out_next      = '0;
               instr_out_next   = '0;
               instr_valid_next = 1'b0;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_next          = branch_addr;
               pc_out_next      = '0;
               instr_out_next   = '0;
               instr_valid_next = 1'b0;
               skid_full_next   = 1'b0;
               skid_pc_next     = '0;
               skid_instr_next  = '0;
               state_next       = FETCH;
            end else if (!freeze) begin
               pc_out_next      = skid_pc;
               instr_out_next   = skid_instr;
               instr_valid_next = 1'b1;
               skid_full_next   = 1'b0;
               state_next       = FETCH;
            end
         end
         DRAIN: begin
            // Keep presenting the abandoned address until memory answers it.
            req_int          = 1'b1;
            imem_addr        = req_addr;
            pc_out_next      = '0;
            instr_out_next   = '0;
            instr_valid_next = 1'b0;
            if (branch_taken)
               pc_next = branch_addr;
            if (imem_ready)
               state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable instruction memory
// whose data is (addr>>2)+0x100.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        instr_valid;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [3:0]  lat;
   logic [3:0]  wait_cnt;

   fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .pc_out       (pc_out),
      .instr_out    (instr_out),
      .instr_valid  (instr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers after lat wait cycles of a continuously held request.
   assign imem_ready = imem_req && (wait_cnt == lat);
   assign imem_rdata = (imem_addr >> 2) + 32'h100;

   always @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (imem_req && !imem_ready)
         wait_cnt <= wait_cnt + 4'd1;
      else
         wait_cnt <= '0;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] epc, input logic [31:0] eins,
                          input logic ev);
      chk({tag, ".pc_out"}, pc_out, epc);
      chk({tag, ".instr_out"}, instr_out, eins);
      chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, ev});
      $display("%t %s pc_out=%h instr_out=%h valid=%0d", $time, tag, pc_out, instr_out, instr_valid);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = '0;
      lat          = 4'd0;
      tick;
      tick;
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk_out("rst", 32'd0, 32'd0, 1'b0);

      // Zero-wait streaming
      rst = 1'b0;
      #1;
      chk("first.req", {31'd0, imem_req}, 32'd1);
      chk("first.addr", imem_addr, 32'd0);
      tick; chk_out("zw0", 32'd4,  32'h100, 1'b1);
      tick; chk_out("zw1", 32'd8,  32'h101, 1'b1);
      tick; chk_out("zw2", 32'd12, 32'h102, 1'b1);

      // Two-cycle latency: valid every third cycle, bubbles between
      lat = 4'd2;
      do_reset;
      tick; chk_out("l2a", 32'd0, 32'd0, 1'b0); chk("l2a.addr", imem_addr, 32'd0);
      tick; chk_out("l2b", 32'd0, 32'd0, 1'b0); chk("l2b.addr", imem_addr, 32'd0);
      tick; chk_out("l2c", 32'd4, 32'h100, 1'b1); chk("l2c.addr", imem_addr, 32'd4);
      tick; chk_out("l2d", 32'd0, 32'd0, 1'b0);
      tick; chk_out("l2e", 32'd0, 32'd0, 1'b0); chk("l2e.addr", imem_addr, 32'd4);
      tick; chk_out("l2f", 32'd8, 32'h101, 1'b1);

      // Freeze for three cycles while a response arrives
      lat = 4'd0;
      do_reset;
      tick; chk_out("fz0", 32'd4, 32'h100, 1'b1);
      freeze = 1'b1;
      tick; chk_out("fz1", 32'd4, 32'h100, 1'b1); chk("fz1.req", {31'd0, imem_req}, 32'd0);
      tick; chk_out("fz2", 32'd4, 32'h100, 1'b1);
      tick; chk_out("fz3", 32'd4, 32'h100, 1'b1);
      freeze = 1'b0;
      tick; chk_out("fz4", 32'd8,  32'h101, 1'b1);
      tick; chk_out("fz5", 32'd12, 32'h102, 1'b1);

      // Branch with ready in the same cycle, then branch while 0x10 is outstanding
      do_reset;
      branch_taken = 1'b1; branch_addr = 32'h10;
      tick;
      branch_taken = 1'b0;
      chk_out("br0", 32'd0, 32'd0, 1'b0); chk("br0.addr", imem_addr, 32'h10);
      lat = 4'd2;
      tick; chk_out("br1", 32'd0, 32'd0, 1'b0);
      branch_taken = 1'b1; branch_addr = 32'h40;
      tick;
      branch_taken = 1'b0;
      chk("dr.req", {31'd0, imem_req}, 32'd1);
      chk("dr.addr", imem_addr, 32'h10);
      chk_out("dr", 32'd0, 32'd0, 1'b0);
      tick; chk("dr2.addr", imem_addr, 32'h40); chk_out("dr2", 32'd0, 32'd0, 1'b0);
      tick; tick; tick;
      chk_out("dr3", 32'h44, 32'h110, 1'b1);

      // Branch while parked in HOLD under freeze
      lat = 4'd0;
      do_reset;
      tick; chk_out("hb0", 32'd4, 32'h100, 1'b1);
      freeze = 1'b1;
      tick; chk("hb1.req", {31'd0, imem_req}, 32'd0);
      branch_taken = 1'b1; branch_addr = 32'h80;
      tick;
      branch_taken = 1'b0;
      chk_out("hb2", 32'd0, 32'd0, 1'b0);
      chk("hb2.req", {31'd0, imem_req}, 32'd1);
      chk("hb2.addr", imem_addr, 32'h80);
      tick; chk_out("hb3", 32'h84, 32'h120, 1'b1);
      freeze = 1'b0;
      tick; chk_out("hb4", 32'h88, 32'h121, 1'b1);

      // PC wrap at the top of the address space, then reset mid-request
      do_reset;
      branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
      tick;
      branch_taken = 1'b0;
      chk("wr0.addr", imem_addr, 32'hFFFF_FFFC);
      tick;
      chk_out("wr1", 32'd0, 32'h4000_00FF, 1'b1);
      chk("wr1.addr", imem_addr, 32'd0);
      lat = 4'd2;
      #1;
      rst = 1'b1;
      #1;
      chk("ar.req", {31'd0, imem_req}, 32'd0);
      chk_out("ar", 32'd0, 32'd0, 1'b0);
      tick;
      rst = 1'b0;
      #1;
      chk("ar2.req", {31'd0, imem_req}, 32'd1);
      chk("ar2.addr", imem_addr, 32'd0);
      tick; tick; tick;
      chk_out("ar3", 32'd4, 32'h100, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
